// File: rtl/debug_unit_controller.sv
// debug_unit_controller: decodes UART host commands into core run/step controls and streams a framed state dump.
// Defining DEBUG_UNIT_CHECKSUM_EN appends an XOR checksum byte ahead of the trailer.
module debug_unit_controller #(
  parameter int NB_DATA     = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGISTERS = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int NB_MEM_ADDR = 5,
  parameter int STEP_SETTLE = 2,
  parameter int NB_STATE    = 3
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NB_BYTE-1:0]             i_rx_data,
  input  logic                           i_rx_done,
  output logic [NB_BYTE-1:0]             o_tx_data,
  output logic                           o_tx_start,
  input  logic                           i_tx_done,
  input  logic                           i_halt,
  input  logic [NB_DATA-1:0]             i_pc,
  input  logic [NB_DATA-1:0]             i_cycles,
  input  logic [N_REGISTERS*NB_DATA-1:0] i_registers,
  output logic [NB_MEM_ADDR-1:0]         o_mem_addr,
  input  logic [NB_DATA-1:0]             i_mem_data,
  output logic                           o_execution_mode,
  output logic                           o_execution_step,
  output logic                           o_du_done,
  output logic [NB_STATE-1:0]            o_state
);
  localparam int NBYTES = NB_DATA / NB_BYTE;
`ifdef DEBUG_UNIT_CHECKSUM_EN
  localparam int CK_EN = 1;
`else
  localparam int CK_EN = 0;
`endif
  // word index: 0 header, 1 pc, 2 cycles, then registers, memory, optional checksum, trailer
  localparam int W_MEM  = 3 + N_REGISTERS;
  localparam int W_CK   = W_MEM + N_MEM_WORDS;
  localparam int W_LAST = W_CK + CK_EN;
  localparam int WW     = $clog2(W_LAST + 1);
  localparam int BW     = $clog2(NBYTES) + 1;
  localparam int SW     = $clog2(STEP_SETTLE + 2);

  typedef enum logic [NB_STATE-1:0] {
    IDLE = NB_STATE'(0), RUN = NB_STATE'(1), STEP = NB_STATE'(2), LOAD = NB_STATE'(3),
    SEND = NB_STATE'(4), WAIT = NB_STATE'(5), DONE = NB_STATE'(6)
  } state_t;

  state_t             state, nxt;
  logic [WW-1:0]      w, reg_idx;
  logic [BW-1:0]      b, last_b;
  logic [SW-1:0]      cnt;
  logic               mem_ph, halted, is_mem, last_w;
  logic [NB_DATA-1:0] shift, word_sel;
  logic [NB_BYTE-1:0] tail;

`ifdef DEBUG_UNIT_CHECKSUM_EN
  logic [NB_BYTE-1:0] ck;
  always_ff @(posedge i_clock) ck <= (!i_reset || state == DONE) ? '0 : (state == SEND) ? ck ^ o_tx_data : ck;
  assign tail = (w == WW'(W_CK)) ? ck : NB_BYTE'(8'h5A);
`else
  assign tail = NB_BYTE'(8'h5A);
`endif

  assign reg_idx = w - WW'(3);
  assign is_mem  = w >= WW'(W_MEM) && w < WW'(W_CK);
  assign last_b  = (w == '0 || w >= WW'(W_CK)) ? '0 : BW'(NBYTES - 1);
  assign last_w  = w == WW'(W_LAST);

  always_comb begin
    word_sel = (w == '0) ? NB_DATA'(NB_BYTE'(8'hA5)) :
               (w == WW'(1)) ? i_pc :
               (w == WW'(2)) ? i_cycles :
               (w < WW'(W_MEM)) ? i_registers[reg_idx*NB_DATA +: NB_DATA] :
               is_mem ? i_mem_data : NB_DATA'(tail);
  end

  always_ff @(posedge i_clock) state <= !i_reset ? IDLE : nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (i_rx_done)
              nxt = (i_rx_data == NB_BYTE'(8'h63) && !halted) ? RUN :
                    (i_rx_data == NB_BYTE'(8'h73) && !halted) ? STEP :
                    (i_rx_data == NB_BYTE'(8'h64)) ? LOAD : IDLE;
      RUN:  nxt = i_halt ? LOAD : RUN;
      STEP: nxt = (cnt == SW'(STEP_SETTLE - 1)) ? LOAD : STEP;
      LOAD: nxt = (is_mem && !mem_ph) ? LOAD : SEND;
      SEND: nxt = WAIT;
      WAIT: if (i_tx_done) nxt = (b != last_b) ? SEND : last_w ? DONE : LOAD;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      w      <= '0;
      b      <= '0;
      cnt    <= '0;
      mem_ph <= 1'b0;
      halted <= 1'b0;
      shift  <= '0;
    end else begin
      if ((state == RUN || state == STEP) && i_halt) halted <= 1'b1;
      cnt    <= (state == STEP) ? cnt + SW'(1) : '0;
      mem_ph <= state == LOAD && is_mem && !mem_ph;
      if (state == LOAD && nxt == SEND) begin
        shift <= word_sel;
        b     <= '0;
      end
      if (state == WAIT && i_tx_done) begin
        if (b != last_b) begin
          b     <= b + BW'(1);
          shift <= shift >> NB_BYTE;
        end else if (!last_w) w <= w + WW'(1);
      end
      if (state == DONE) w <= '0;
    end
  end

  always_comb begin
    o_execution_mode = state == RUN;
    o_execution_step = state == STEP && cnt == '0;
    o_tx_start       = state == SEND;
    o_du_done        = state == DONE;
    o_state          = state;
    o_tx_data        = shift[NB_BYTE-1:0];
    o_mem_addr       = (state == LOAD && is_mem) ? NB_MEM_ADDR'(w - WW'(W_MEM)) : '0;
  end
endmodule
